// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver constants and FSM encoding (UART_RX_PARITY_EN adds PARITY)
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
    localparam state_t ST_AFTER_DATA = ST_PARITY;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } state_t;
    localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-word bundle between the receiver FSM and its consumer
interface uart_rx_if #(
    parameter int NB_DATA = 8
) ();

    logic [NB_DATA-1:0] data;
    logic               rx_done;
    logic               frame_err;
    logic               parity_err;

    modport master (output data, rx_done, frame_err, parity_err);
    modport slave  (input  data, rx_done, frame_err, parity_err);

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with configurable reset level
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta <= RESET_VAL;
            o_q  <= RESET_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - oversampled frame FSM; UART_RX_PARITY_EN enables the even-parity bit
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic      i_clk,
    input  logic      i_reset,
    input  logic      i_tick,
    input  logic      rx_s,
    uart_rx_if.master rx_bus
);

    localparam int NW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    // Tick counter widens only when the stop period exceeds one bit time
    localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;

    localparam logic [SW-1:0] S_MID  = SW'(MID_SAMPLE);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

    state_t               state, state_n;
    logic [SW-1:0]        s_cnt, s_cnt_n;
    logic [NW-1:0]        n_cnt, n_cnt_n;
    logic [NB_DATA-1:0]   b_reg, b_n;
    logic [NB_DATA-1:0]   data_q, data_n;
    logic                 done_q, done_n;
    logic                 ferr_q, ferr_n;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_n;
    logic                 perr_q, perr_n;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= ST_IDLE;
            s_cnt  <= '0;
            n_cnt  <= '0;
            b_reg  <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q  <= 1'b0;
            perr_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            s_cnt  <= s_cnt_n;
            n_cnt  <= n_cnt_n;
            b_reg  <= b_n;
            data_q <= data_n;
            done_q <= done_n;
            ferr_q <= ferr_n;
`ifdef UART_RX_PARITY_EN
            par_q  <= par_n;
            perr_q <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (!rx_s) state_n = ST_START;
            ST_START:  if (i_tick && s_cnt == S_MID) state_n = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (i_tick && s_cnt == S_LAST && n_cnt == N_LAST) state_n = ST_AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (i_tick && s_cnt == S_LAST) state_n = ST_STOP;
`endif
            ST_STOP:   if (i_tick && s_cnt == S_STOP) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        s_cnt_n = s_cnt;
        n_cnt_n = n_cnt;
        b_n     = b_reg;
        data_n  = data_q;
        done_n  = 1'b0;
        ferr_n  = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_n   = par_q;
        perr_n  = perr_q;
`endif
        case (state)
            ST_IDLE: if (!rx_s) s_cnt_n = '0;
            ST_START: if (i_tick) begin
                if (s_cnt == S_MID) begin
                    s_cnt_n = '0;
                    n_cnt_n = '0;
                end else begin
                    s_cnt_n = s_cnt + SW'(1);
                end
            end
            ST_DATA: if (i_tick) begin
                if (s_cnt == S_LAST) begin
                    s_cnt_n = '0;
                    b_n     = {rx_s, b_reg[NB_DATA-1:1]};
                    if (n_cnt != N_LAST) n_cnt_n = n_cnt + NW'(1);
                end else begin
                    s_cnt_n = s_cnt + SW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (i_tick) begin
                if (s_cnt == S_LAST) begin
                    s_cnt_n = '0;
                    par_n   = (^b_reg) ^ rx_s;
                end else begin
                    s_cnt_n = s_cnt + SW'(1);
                end
            end
`endif
            // Results land one cycle after the stop sample, together with the done pulse
            ST_STOP: if (i_tick) begin
                if (s_cnt == S_STOP) begin
                    s_cnt_n = '0;
                    data_n  = b_reg;
                    done_n  = 1'b1;
                    ferr_n  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                    perr_n  = par_q;
`endif
                end else begin
                    s_cnt_n = s_cnt + SW'(1);
                end
            end
            default: s_cnt_n = '0;
        endcase
    end

    assign rx_bus.data      = data_q;
    assign rx_bus.rx_done   = done_q;
    assign rx_bus.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.parity_err = perr_q;
`else
    assign rx_bus.parity_err = 1'b0;
`endif

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver top: input synchronizer plus frame FSM (UART_RX_PARITY_EN selects parity)
module uart_rx #(
    parameter int NB_DATA = 8,
    parameter int SB_TICK = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    logic rx_s;

    uart_rx_if #(.NB_DATA(NB_DATA)) rx_bus ();

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    uart_rx_fsm #(
        .NB_DATA (NB_DATA),
        .SB_TICK (SB_TICK)
    ) u_fsm (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_tick  (i_tick),
        .rx_s    (rx_s),
        .rx_bus  (rx_bus)
    );

    assign o_data       = rx_bus.data;
    assign o_rx_done    = rx_bus.rx_done;
    assign o_frame_err  = rx_bus.frame_err;
    assign o_parity_err = rx_bus.parity_err;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16, oversampling ticks per stop bit (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 SHALL have port i_clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port i_tick  input  1  16x-oversampling strobe, one i_clk cycle wide, from the baud rate generator.
REQ-006 SHALL have port i_rx  input  1  serial line, asynchronous to i_clk, idle high.
REQ-007 SHALL have port o_data  output  NB_DATA  last received word, LSB = first data bit on the line.
REQ-008 SHALL have port o_rx_done  output  1  one-cycle pulse when a frame completes.
REQ-009 SHALL have port o_frame_err  output  1  stop bit sampled low in the last frame; valid with o_rx_done and held until the next frame completes.
REQ-010 SHALL have port o_parity_err  output  1  parity mismatch in the last frame; valid with o_rx_done and held until the next frame completes.

Function
REQ-011 SHALL pass i_rx through a 2-flop synchronizer; all FSM decisions use the synchronized value (rx_s), adding 2 cycles of latency.
REQ-012 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP, with a 4-bit tick counter s_cnt and a bit counter n_cnt of width $clog2(NB_DATA).
REQ-013 IDLE: when rx_s==0, SHALL go to START with s_cnt=0, regardless of i_tick.
REQ-014 START: on each i_tick, SHALL increment s_cnt; on a tick at s_cnt==7, SHALL go to DATA with s_cnt=0 and n_cnt=0 if rx_s==0, otherwise SHALL return to IDLE (glitch rejection, no o_rx_done).
REQ-015 DATA: on a tick at s_cnt==15, SHALL shift rx_s into the MSB of the shift register (right shift, LSB first) and clear s_cnt; at n_cnt==NB_DATA-1, SHALL go to PARITY (if enabled) or STOP, otherwise increment n_cnt.
REQ-016 STOP: on a tick at s_cnt==SB_TICK-1, SHALL in the next cycle load o_data from the shift register, set o_frame_err=~rx_s, pulse o_rx_done for exactly 1 cycle, and return to IDLE.
REQ-017 SHALL change no state while i_tick==0, except the IDLE-to-START transition and the synchronizer.
REQ-018 SHALL hold o_data, o_frame_err and o_parity_err stable between o_rx_done pulses.
REQ-019 A frame with a framing error SHALL still update o_data and pulse o_rx_done.
REQ-020 If the line stays low after a frame ends (break condition), SHALL re-enter START from IDLE and complete another frame.

Reset
REQ-021 Asserting i_reset at any time, including mid-frame, SHALL immediately force: state=IDLE, s_cnt=0, n_cnt=0, shift register=0, o_data=0, o_rx_done=0, o_frame_err=0, o_parity_err=0, synchronizer flops=1.
REQ-022 After i_reset deasserts, SHALL not detect a start bit until rx_s==0.

Configuration
REQ-023 With UART_RX_PARITY_EN defined, SHALL use the PARITY state: on a tick at s_cnt==15, SHALL sample the even-parity bit and set o_parity_err = (XOR of data bits) ^ rx_s when o_rx_done pulses, then go to STOP.
REQ-024 Without UART_RX_PARITY_EN, the PARITY state SHALL not exist, DATA SHALL go directly to STOP, and o_parity_err SHALL be tied to 0; the port list SHALL be unchanged.

Structure
REQ-025 SHALL place the FSM state encoding (localparam/typedef, 3 bits) and the constants OVERSAMPLE=16 and MID_SAMPLE=7 in the shared package uart_pkg.
REQ-026 SHALL implement the synchronizer as sub-module sync_2ff with reset value 1.

Verification (bench drives i_tick every 16 clocks; 1 bit = 256 clocks)
REQ-027 Frame 0 (start), 0x55 LSB first, 1 (stop) -> one o_rx_done pulse, o_data=0x55, o_frame_err=0.
REQ-028 Low pulse on i_rx of 64 clocks -> no o_rx_done, FSM back in IDLE, o_data unchanged.
REQ-029 Frame 0xA3 with stop bit driven 0 -> o_rx_done pulses, o_data=0xA3, o_frame_err=1; next clean frame 0x0F -> o_frame_err=0.
REQ-030 i_reset asserted at bit 4 of 0xFF, released, then frame 0x3C -> o_data=0x00 during reset, then 0x3C with exactly one done pulse.
REQ-031 With UART_RX_PARITY_EN: 0x07 with parity 1 -> o_parity_err=0; 0x07 with parity 0 -> o_parity_err=1.
REQ-032 Back-to-back frames 0x01, 0x80 with no idle gap -> two done pulses, data 0x01 then 0x80.
